instr_fetch_assembler: RTL and testbench
========================================

# instr_fetch_assembler

Parametrised instruction fetch-and-assemble unit. It sits between the byte-wide instruction ROM (synchronous read, 1-cycle latency) and the decoder. It issues sequential byte reads from a program counter and packs N bytes into one instruction word in a selectable byte order. The word is presented to the decoder on a valid/ready handshake, and a jump port redirects the program counter and aborts any partial assembly.

## Interface
- BYTE_W, 8, width of one memory byte lane
- N_BYTES, 4, bytes per instruction (2..8); counter width = clog2(N_BYTES+1)
- ADDR_W, 8, program-counter / memory address width
- BIG_ENDIAN, 1, 1: first-fetched byte goes to MSB lane; 0: to LSB lane
- RESET_ADDR, 0, PC value after reset

- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- jump_valid  in  1  redirect request, sampled on clk
- jump_addr  in  ADDR_W  new PC when jump_valid=1
- mem_rd_en  out  1  read strobe to ROM
- mem_addr  out  ADDR_W  read address to ROM
- mem_rd_data  in  BYTE_W  ROM data, valid the cycle after a mem_rd_en cycle
- instr_valid  out  1  instr_data/instr_addr hold a complete word
- instr_ready  in  1  decoder accepts word
- instr_data  out  BYTE_W*N_BYTES  assembled instruction
- instr_addr  out  ADDR_W  address of first byte of instr_data
- instr_count  out  16  number of completed transfers, wraps at 2^16

## Operation
- States: FETCH, HOLD. Reset → FETCH with pc=RESET_ADDR, issue count=0, capture count=0.
- FETCH, issue side: while issue count < N_BYTES, drive mem_rd_en=1 and mem_addr=pc+issue count (mod 2^ADDR_W), then increment the issue count.
- FETCH, capture side: register rd_pending = previous cycle's mem_rd_en. When rd_pending=1, write mem_rd_data into a lane and increment the capture count.
  - BIG_ENDIAN=1: lane index N_BYTES-1-capture count.
  - BIG_ENDIAN=0: lane index = capture count.
- When byte N_BYTES-1 is captured: instr_data is updated, instr_addr=pc, instr_valid=1, state→HOLD. mem_rd_en=0 in HOLD.
- HOLD: instr_data, instr_addr and instr_valid are stable until transfer (instr_valid & instr_ready). On transfer:
  - pc += N_BYTES (mod 2^ADDR_W)
  - instr_count += 1
  - instr_valid=0 next cycle
  - counts cleared, state→FETCH
- jump_valid=1 in any state, highest priority. The next cycle:
  - pc=jump_addr, counts cleared, rd_pending=0 (the in-flight byte is discarded)
  - instr_valid=0, state FETCH
  - mem_rd_en=1 with mem_addr=jump_addr.
- Jump and transfer in the same cycle: the transfer completes (instr_count increments) and the jump sets the PC; the PC increment is suppressed.
- Partially assembled lanes are never visible on instr_data. The output register updates only on completion.
- Reset mid-operation: all state returns immediately to reset values; any in-flight ROM data is ignored.

## Timing
- Reset values: mem_rd_en=0, mem_addr=RESET_ADDR, instr_valid=0, instr_data=0, instr_addr=0, instr_count=0.
- Fetch cycles: first rising edge after rst falls = cycle 0; mem_rd_en=1 in cycles 0..N_BYTES-1 with mem_addr=pc+k.
- Data timing: byte k arrives in cycle k+1 and is captured at the end of cycle k+1. instr_valid=1 from cycle N_BYTES+1, a latency of N_BYTES+1 cycles.
- Back-to-back throughput with instr_ready=1: one word per N_BYTES+2 cycles. The next fetch cycle 0 follows the transfer cycle.
- Jump latency: jump sampled in cycle j gives mem_addr=jump_addr in cycle j+1 and instr_valid at j+N_BYTES+2.
- PC wrap: addresses roll from 2^ADDR_W-1 to 0 within a word with no gap.

## Test plan
- Reset + default params, ROM[0..3]=11,22,33,44:
  - instr_valid rises at cycle 5
  - instr_data=0x11223344, instr_addr=0x00
  - mem_rd_en high exactly in cycles 0..3.
- BIG_ENDIAN=0, same ROM → instr_data=0x44332211. With N_BYTES=2, ROM[0..1]=AB,CD → 0xCDAB, valid at cycle 3.
- Backpressure: hold instr_ready=0 for 10 cycles → word stable and no reads issued. Raise ready → instr_count=1 and the next fetch starts at mem_addr=0x04 the following cycle.
- Jump to 0x80 during fetch cycle 2 → the stale byte is not used; the next word has instr_addr=0x80 and data=ROM[0x80..0x83]. Also apply jump_valid together with a transfer → instr_count increments and next pc=jump_addr.
- Wrap: jump to 0xFE, ROM[FE,FF,00,01]=A1,B2,C3,D4 → instr_data=0xA1B2C3D4, next instr_addr=0x02.
- Assert rst for one cycle mid-fetch and during HOLD → all outputs return to reset values immediately; refetch starts from RESET_ADDR.

Source files
------------

// File: rtl/instr_fetch_assembler.sv
// Instruction fetch-and-assemble unit: streams N_BYTES sequential bytes from a
// 1-cycle-latency byte ROM and presents them as one word on a valid/ready port.
module instr_fetch_assembler #(
    parameter int unsigned       BYTE_W     = 8,
    parameter int unsigned       N_BYTES    = 4,
    parameter int unsigned       ADDR_W     = 8,
    parameter bit                BIG_ENDIAN = 1'b1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      jump_valid,
    input  logic [ADDR_W-1:0]         jump_addr,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [BYTE_W-1:0]         mem_rd_data,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [BYTE_W*N_BYTES-1:0] instr_data,
    output logic [ADDR_W-1:0]         instr_addr,
    output logic [15:0]               instr_count
);

    localparam int unsigned       CNT_W    = $clog2(N_BYTES + 1);
    localparam int unsigned       WORD_W   = BYTE_W * N_BYTES;
    localparam logic [CNT_W-1:0]  N_CNT    = CNT_W'(N_BYTES);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0]  ONE_CNT  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] N_ADDR   = ADDR_W'(N_BYTES);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   cap_cnt_q, cap_cnt_d;
    logic               rd_pending_q, rd_pending_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               valid_q, valid_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic [ADDR_W-1:0]  iaddr_q, iaddr_d;
    logic [15:0]        count_q, count_d;
    logic [WORD_W-1:0]  lanes_q, lanes_d;
    logic [CNT_W-1:0]   lane_idx;
    logic               transfer;

    assign transfer = valid_q & instr_ready;
    assign lane_idx = BIG_ENDIAN ? (LAST_CNT - cap_cnt_q) : cap_cnt_q;

    // Assembly buffer with the arriving byte merged in; the completed word is
    // taken from here so the last byte reaches instr_data on the same edge.
    always_comb begin
        lanes_d = lanes_q;
        if (state_q == FETCH && rd_pending_q) begin
            for (int unsigned i = 0; i < N_BYTES; i++) begin
                if (lane_idx == CNT_W'(i)) begin
                    lanes_d[i*BYTE_W +: BYTE_W] = mem_rd_data;
                end
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a
        // path that skips the assignment would infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        issue_cnt_d  = issue_cnt_q;
        cap_cnt_d    = cap_cnt_q;
        rd_pending_d = rd_en_q;
        rd_en_d      = 1'b0;
        addr_d       = addr_q;
        valid_d      = valid_q;
        data_d       = data_q;
        iaddr_d      = iaddr_q;
        count_d      = count_q;

        if (jump_valid) begin
            // Byte 0 of the new target is issued on the redirect edge itself,
            // and whatever the ROM returns next belongs to the old stream.
            pc_d         = jump_addr;
            issue_cnt_d  = ONE_CNT;
            cap_cnt_d    = '0;
            rd_pending_d = 1'b0;
            rd_en_d      = 1'b1;
            addr_d       = jump_addr;
            valid_d      = 1'b0;
            state_d      = FETCH;
            if (transfer) begin
                count_d = count_q + 16'd1;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (issue_cnt_q < N_CNT) begin
                        rd_en_d     = 1'b1;
                        addr_d      = pc_q + ADDR_W'(issue_cnt_q);
                        issue_cnt_d = issue_cnt_q + ONE_CNT;
                    end
                    if (rd_pending_q) begin
                        cap_cnt_d = cap_cnt_q + ONE_CNT;
                        if (cap_cnt_q == LAST_CNT) begin
                            data_d  = lanes_d;
                            iaddr_d = pc_q;
                            valid_d = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (transfer) begin
                        pc_d        = pc_q + N_ADDR;
                        count_d     = count_q + 16'd1;
                        valid_d     = 1'b0;
                        cap_cnt_d   = '0;
                        issue_cnt_d = ONE_CNT;
                        rd_en_d     = 1'b1;
                        addr_d      = pc_q + N_ADDR;
                        state_d     = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_ADDR;
            issue_cnt_q  <= '0;
            cap_cnt_q    <= '0;
            rd_pending_q <= 1'b0;
            rd_en_q      <= 1'b0;
            addr_q       <= RESET_ADDR;
            valid_q      <= 1'b0;
            data_q       <= '0;
            iaddr_q      <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            issue_cnt_q  <= issue_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_en_q      <= rd_en_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            iaddr_q      <= iaddr_d;
            count_q      <= count_d;
        end
    end

    // NOTE: the assembly buffer is deliberately left without reset; every lane
    // is rewritten before it can reach instr_data, so a reset would buy nothing.
    always_ff @(posedge clk) begin
        lanes_q <= lanes_d;
    end

    assign mem_rd_en   = rd_en_q;
    assign mem_addr    = addr_q;
    assign instr_valid = valid_q;
    assign instr_data  = data_q;
    assign instr_addr  = iaddr_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_assembler.sv
// Directed bench for instr_fetch_assembler: default big-endian instance plus
// little-endian N=4 and N=2 instances sharing clock and reset.
module tb_instr_fetch_assembler;

    logic clk;
    logic rst;

    logic        m_jv;
    logic [7:0]  m_jaddr;
    logic        m_rd_en;
    logic [7:0]  m_addr;
    logic [7:0]  m_rd_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [7:0]  m_iaddr;
    logic [15:0] m_count;

    logic        le_rd_en;
    logic [7:0]  le_addr;
    logic [7:0]  le_rd_data;
    logic        le_valid;
    logic [31:0] le_data;
    logic [7:0]  le_iaddr;
    logic [15:0] le_count;

    logic        n2_rd_en;
    logic [7:0]  n2_addr;
    logic [7:0]  n2_rd_data;
    logic        n2_valid;
    logic [15:0] n2_data;
    logic [7:0]  n2_iaddr;
    logic [15:0] n2_count;

    logic [7:0] rom  [256];
    logic [7:0] rom2 [256];

    int n_cmp;
    int n_bad;

    instr_fetch_assembler dut (
        .clk(clk), .rst(rst), .jump_valid(m_jv), .jump_addr(m_jaddr),
        .mem_rd_en(m_rd_en), .mem_addr(m_addr), .mem_rd_data(m_rd_data),
        .instr_valid(m_valid), .instr_ready(m_ready), .instr_data(m_data),
        .instr_addr(m_iaddr), .instr_count(m_count)
    );

    instr_fetch_assembler #(.BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .jump_valid(1'b0), .jump_addr(8'h00),
        .mem_rd_en(le_rd_en), .mem_addr(le_addr), .mem_rd_data(le_rd_data),
        .instr_valid(le_valid), .instr_ready(1'b0), .instr_data(le_data),
        .instr_addr(le_iaddr), .instr_count(le_count)
    );

    instr_fetch_assembler #(.N_BYTES(2), .BIG_ENDIAN(1'b0)) dut_n2 (
        .clk(clk), .rst(rst), .jump_valid(1'b0), .jump_addr(8'h00),
        .mem_rd_en(n2_rd_en), .mem_addr(n2_addr), .mem_rd_data(n2_rd_data),
        .instr_valid(n2_valid), .instr_ready(1'b0), .instr_data(n2_data),
        .instr_addr(n2_iaddr), .instr_count(n2_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read ROM models, one cycle of latency.
    always @(posedge clk) begin
        if (m_rd_en)  m_rd_data  <= rom[m_addr];
        if (le_rd_en) le_rd_data <= rom[le_addr];
        if (n2_rd_en) n2_rd_data <= rom2[n2_addr];
    end

    // Waits for instr_valid of the main instance; returns cycles waited or -1.
    task automatic wait_valid(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (m_valid === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if (m_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en got %b want 0", m_rd_en); end
        n_cmp++; if (m_addr !== 8'h00) begin n_bad++; $display("FAIL reset_mem_addr got %h want 00", m_addr); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", m_valid); end
        n_cmp++; if (m_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", m_data); end
        n_cmp++; if (m_iaddr !== 8'h00) begin n_bad++; $display("FAIL reset_iaddr got %h want 00", m_iaddr); end
        n_cmp++; if (m_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", m_count); end
    endtask

    task automatic test_fetch_latency;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (m_rd_en !== (k <= 3)) begin n_bad++; $display("FAIL lat_rd_en cycle %0d got %b want %b", k, m_rd_en, (k <= 3)); end
            if (k <= 3) begin
                n_cmp++;
                if (m_addr !== 8'(k)) begin n_bad++; $display("FAIL lat_mem_addr cycle %0d got %h want %h", k, m_addr, 8'(k)); end
            end
            n_cmp++;
            if (m_valid !== (k >= 5)) begin n_bad++; $display("FAIL lat_valid cycle %0d got %b want %b", k, m_valid, (k >= 5)); end
            n_cmp++;
            if (le_valid !== (k >= 5)) begin n_bad++; $display("FAIL le_valid cycle %0d got %b want %b", k, le_valid, (k >= 5)); end
            n_cmp++;
            if (n2_valid !== (k >= 3)) begin n_bad++; $display("FAIL n2_valid cycle %0d got %b want %b", k, n2_valid, (k >= 3)); end
            if (k == 3) begin
                n_cmp++;
                if (n2_data !== 16'hCDAB) begin n_bad++; $display("FAIL n2_data got %h want CDAB", n2_data); end
            end
            if (k == 5) begin
                n_cmp++;
                if (m_data !== 32'h11223344) begin n_bad++; $display("FAIL be_data got %h want 11223344", m_data); end
                n_cmp++;
                if (m_iaddr !== 8'h00) begin n_bad++; $display("FAIL be_iaddr got %h want 00", m_iaddr); end
                n_cmp++;
                if (le_data !== 32'h44332211) begin n_bad++; $display("FAIL le_data got %h want 44332211", le_data); end
            end
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (m_valid !== 1'b1 || m_data !== 32'h11223344 || m_rd_en !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d got valid=%b data=%h rd_en=%b want 1/11223344/0", k, m_valid, m_data, m_rd_en);
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        n_cmp++; if (m_count !== 16'd1) begin n_bad++; $display("FAIL bp_count got %0d want 1", m_count); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid_drop got %b want 0", m_valid); end
        n_cmp++;
        if (m_rd_en !== 1'b1 || m_addr !== 8'h04) begin n_bad++; $display("FAIL bp_next_fetch got rd_en=%b addr=%h want 1/04", m_rd_en, m_addr); end
        wait_valid(cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL b2b_latency got %0d want 5", cyc); end
        n_cmp++; if (m_data !== 32'h04050607) begin n_bad++; $display("FAIL word2_data got %h want 04050607", m_data); end
        n_cmp++; if (m_iaddr !== 8'h04) begin n_bad++; $display("FAIL word2_iaddr got %h want 04", m_iaddr); end
    endtask

    task automatic test_jump_mid_fetch;
        int cyc;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        m_jv    = 1'b1;
        m_jaddr = 8'h80;
        @(negedge clk);
        m_jv = 1'b0;
        n_cmp++;
        if (m_rd_en !== 1'b1 || m_addr !== 8'h80 || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL jump_redirect got rd_en=%b addr=%h valid=%b want 1/80/0", m_rd_en, m_addr, m_valid);
        end
        wait_valid(cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL jump_latency got %0d want 5", cyc); end
        n_cmp++; if (m_data !== 32'h80818283) begin n_bad++; $display("FAIL jump_data got %h want 80818283", m_data); end
        n_cmp++; if (m_iaddr !== 8'h80) begin n_bad++; $display("FAIL jump_iaddr got %h want 80", m_iaddr); end
        n_cmp++; if (m_count !== 16'd2) begin n_bad++; $display("FAIL jump_count got %0d want 2", m_count); end
    endtask

    task automatic test_jump_with_transfer;
        int cyc;
        m_ready = 1'b1;
        m_jv    = 1'b1;
        m_jaddr = 8'h40;
        @(negedge clk);
        m_ready = 1'b0;
        m_jv    = 1'b0;
        n_cmp++; if (m_count !== 16'd3) begin n_bad++; $display("FAIL jt_count got %0d want 3", m_count); end
        n_cmp++;
        if (m_rd_en !== 1'b1 || m_addr !== 8'h40 || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL jt_redirect got rd_en=%b addr=%h valid=%b want 1/40/0", m_rd_en, m_addr, m_valid);
        end
        wait_valid(cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL jt_latency got %0d want 5", cyc); end
        n_cmp++;
        if (m_iaddr !== 8'h40 || m_data !== 32'h40414243) begin n_bad++; $display("FAIL jt_word got addr=%h data=%h want 40/40414243", m_iaddr, m_data); end
    endtask

    task automatic test_wrap;
        int cyc;
        rom[8'hFE] = 8'hA1;
        rom[8'hFF] = 8'hB2;
        rom[8'h00] = 8'hC3;
        rom[8'h01] = 8'hD4;
        m_jv    = 1'b1;
        m_jaddr = 8'hFE;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            m_jv = 1'b0;
            n_cmp++;
            if (m_rd_en !== 1'b1 || m_addr !== 8'(8'hFD + k)) begin
                n_bad++;
                $display("FAIL wrap_addr step %0d got rd_en=%b addr=%h want 1/%h", k, m_rd_en, m_addr, 8'(8'hFD + k));
            end
        end
        wait_valid(cyc);
        n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL wrap_latency got %0d want 2", cyc); end
        n_cmp++; if (m_data !== 32'hA1B2C3D4) begin n_bad++; $display("FAIL wrap_data got %h want A1B2C3D4", m_data); end
        n_cmp++; if (m_iaddr !== 8'hFE) begin n_bad++; $display("FAIL wrap_iaddr got %h want FE", m_iaddr); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        n_cmp++;
        if (m_addr !== 8'h02 || m_count !== 16'd4) begin n_bad++; $display("FAIL wrap_next got addr=%h count=%0d want 02/4", m_addr, m_count); end
        wait_valid(cyc);
        n_cmp++; if (m_iaddr !== 8'h02) begin n_bad++; $display("FAIL wrap_next_iaddr got %h want 02", m_iaddr); end
        rom[8'h00] = 8'h11;
        rom[8'h01] = 8'h22;
    endtask

    task automatic test_reset_mid;
        int cyc;
        // Reset while holding a completed word.
        rst = 1'b1;
        #1;
        n_cmp++;
        if (m_valid !== 1'b0 || m_data !== 32'h0 || m_iaddr !== 8'h00 || m_count !== 16'd0 || m_rd_en !== 1'b0 || m_addr !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_hold got valid=%b data=%h iaddr=%h count=%0d rd_en=%b addr=%h want all 0",
                     m_valid, m_data, m_iaddr, m_count, m_rd_en, m_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (m_rd_en !== 1'b1 || m_addr !== 8'h00) begin n_bad++; $display("FAIL rst_hold_refetch got rd_en=%b addr=%h want 1/00", m_rd_en, m_addr); end
        wait_valid(cyc);
        n_cmp++;
        if (cyc !== 5 || m_data !== 32'h11223344) begin n_bad++; $display("FAIL rst_hold_word got cyc=%0d data=%h want 5/11223344", cyc, m_data); end

        // Reset in fetch cycle 2 of a fresh fetch.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (m_rd_en !== 1'b0 || m_addr !== 8'h00 || m_valid !== 1'b0 || m_count !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_fetch got rd_en=%b addr=%h valid=%b count=%0d want 0/00/0/0", m_rd_en, m_addr, m_valid, m_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (m_rd_en !== 1'b1 || m_addr !== 8'h00) begin n_bad++; $display("FAIL rst_fetch_refetch got rd_en=%b addr=%h want 1/00", m_rd_en, m_addr); end
        wait_valid(cyc);
        n_cmp++;
        if (cyc !== 5 || m_data !== 32'h11223344 || m_iaddr !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_fetch_word got cyc=%0d data=%h iaddr=%h want 5/11223344/00", cyc, m_data, m_iaddr);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        m_jv    = 1'b0;
        m_jaddr = 8'h00;
        m_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom[i]  = 8'(i);
            rom2[i] = 8'(i);
        end
        rom[0]  = 8'h11;
        rom[1]  = 8'h22;
        rom[2]  = 8'h33;
        rom[3]  = 8'h44;
        rom2[0] = 8'hAB;
        rom2[1] = 8'hCD;

        test_reset;
        test_fetch_latency;
        test_backpressure;
        test_jump_mid_fetch;
        test_jump_with_transfer;
        test_wrap;
        test_reset_mid;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
